// File: rtl/load_store_ctrl.sv
// load_store_ctrl
//   Byte/halfword/word load-store sequencer that sits between the core
//   control FSM and a single-port, fixed-latency data RAM. Sub-word stores
//   are done as read-modify-write. Loads are sign- or zero-extended.
//
// Parameters
//   MEM_AW  word-address width of the data RAM
//   RD_LAT  RAM read latency in clocks (1 or 2)
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req, we, funct3     request handshake (sampled only while ready=1)
//   addr, wdata         byte address, right-aligned store data
//   ready, done, err    idle flag, one-cycle completion pulse, error flag
//   rdata               extended load result (held between loads)
//   mem_addr, mem_wdata, mem_wren, mem_q   data RAM port
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned H/W accesses complete
//                         with err=1 and never touch the RAM.
module load_store_ctrl #(
    parameter int MEM_AW = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] LD_CAP  = 3'd2;
    localparam logic [2:0] MERGE   = 3'd3;
    localparam logic [2:0] WR      = 3'd4;
    localparam logic [2:0] FIN     = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;

    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

    logic [2:0]        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lane_q;
    logic [MEM_AW-1:0] addr_q;
    logic [15:0]       wd_q;
    logic [31:0]       wr_q;
    logic [31:0]       rdata_q;
    logic [1:0]        cnt;

    logic              bad;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       loaded;
    logic [31:0]       merged;

    // Upper address bits wrap modulo the RAM size.
    logic unused_addr;
    assign unused_addr = ^addr[31:MEM_AW+2];

    // Request legality, evaluated on the un-latched inputs at acceptance.
    always_comb begin
        bad = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: bad = 1'b0;
            3'b100, 3'b101:         bad = we;
            default:                bad = 1'b1;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        if (funct3[1:0] == 2'b01 && addr[0])
            bad = 1'b1;
        if (funct3 == 3'b010 && addr[1:0] != 2'b00)
            bad = 1'b1;
`endif
    end

    // Lane extraction and extension of the returned RAM word.
    always_comb begin
        byte_sel = mem_q[{lane_q, 3'b000} +: 8];
        half_sel = mem_q[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  loaded = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  loaded = {{16{half_sel[15]}}, half_sel};
            3'b100:  loaded = {24'd0, byte_sel};
            3'b101:  loaded = {16'd0, half_sel};
            default: loaded = mem_q;
        endcase
    end

    // Sub-word store: only SB (funct3[0]=0) and SH (funct3[0]=1) get here.
    always_comb begin
        merged = mem_q;
        if (!f3_q[0])
            merged[{lane_q, 3'b000} +: 8] = wd_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            addr_q  <= '0;
            wd_q    <= '0;
            wr_q    <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q   <= we;
                        f3_q   <= funct3;
                        lane_q <= addr[1:0];
                        addr_q <= addr[MEM_AW+1:2];
                        wd_q   <= wdata[15:0];
                        cnt    <= '0;
                        if (bad) begin
                            state <= ERR;
                        end else if (we && funct3 == 3'b010) begin
                            wr_q  <= wdata;
                            state <= WR;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == LAST_WAIT)
                        state <= LD_CAP;
                    else
                        cnt <= cnt + 2'd1;
                end
                LD_CAP: begin
                    if (we_q) begin
                        wr_q  <= merged;
                        state <= MERGE;
                    end else begin
                        rdata_q <= loaded;
                        state   <= FIN;
                    end
                end
                MERGE:   state <= FIN;
                WR:      state <= FIN;
                FIN:     state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign done      = (state == FIN) || (state == ERR);
    assign err       = (state == ERR);
    assign mem_wren  = (state == WR) || (state == MERGE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wr_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Self-checking bench for load_store_ctrl with a 2-clock-latency RAM model.
module tb_load_store_ctrl;

    localparam int MEM_AW = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req = 1'b0;
    logic              we = 1'b0;
    logic [2:0]        funct3 = 3'd0;
    logic [31:0]       addr = '0;
    logic [31:0]       wdata = '0;
    logic              ready;
    logic              done;
    logic [31:0]       rdata;
    logic              err;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wren;
    logic [31:0]       mem_q = '0;

    load_store_ctrl #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done),
        .rdata(rdata), .err(err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // RAM with two-stage read pipeline (RD_LAT=2).
    logic [31:0] ram [256] = '{default: '0};
    logic [31:0] p1 = '0;
    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        p1    <= ram[mem_addr];
        mem_q <= p1;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              e_err;
        logic [31:0]       rd;
        int unsigned       due;
        int unsigned       wrens;
        logic [MEM_AW-1:0] ma;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned wren_cnt = 0;
    logic [31:0] held = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_wren) begin
                wren_cnt++;
                if (q.size() > 0) check("wr_addr", 32'(mem_addr), 32'(q[0].ma));
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("err", 32'(err), 32'(e.e_err));
                    check("rdata", rdata, e.rd);
                    check("latency", 32'(cyc), 32'(e.due));
                    check("wren_count", 32'(wren_cnt), 32'(e.wrens));
                    wren_cnt = 0;
                end
            end else begin
                check("err_without_done", 32'(err), 32'd0);
            end
        end
    end

    task automatic start(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err, input logic is_load,
                         input logic [31:0] e_rd, input int unsigned lat,
                         input int unsigned nwr);
        exp_t e;
        int unsigned n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", 32'(ready), 32'd1);
        we = w; funct3 = f; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        if (is_load && !e_err) held = e_rd;
        e.e_err = e_err;
        e.rd    = held;
        e.due   = cyc + lat - 1;
        e.wrens = nwr;
        e.ma    = a[MEM_AW+1:2];
        q.push_back(e);
    endtask

    task automatic wait_done();
        int unsigned n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("done_timeout", 32'd0, 32'd1);
            q.delete();
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic e_err, input logic is_load,
                         input logic [31:0] e_rd, input int unsigned lat,
                         input int unsigned nwr);
        start(w, f, a, d, e_err, is_load, e_rd, lat, nwr);
        wait_done();
    endtask

    // Store latencies: SW 2, SB/SH RD_LAT+3; load RD_LAT+2; error 1.
    task automatic st(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        issue(1'b1, f, a, d, 1'b0, 1'b0, 32'd0, (f == 3'b010) ? 2 : RD_LAT + 3, 1);
    endtask

    task automatic ld(input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
        issue(1'b0, f, a, 32'd0, 1'b0, 1'b1, exp, RD_LAT + 2, 0);
    endtask

    task automatic bad_req(input logic w, input logic [2:0] f, input logic [31:0] a);
        issue(w, f, a, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 1, 0);
    endtask

    initial begin
        #3;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        st(3'b010, 32'h10, 32'hDEAD_BEEF);
        ld(3'b010, 32'h10, 32'hDEAD_BEEF);
        st(3'b000, 32'h11, 32'h0000_00AA);
        ld(3'b010, 32'h10, 32'hDEAD_AAEF);
        ld(3'b000, 32'h11, 32'hFFFF_FFAA);
        ld(3'b100, 32'h11, 32'h0000_00AA);
        st(3'b001, 32'h12, 32'h0000_1234);
        ld(3'b010, 32'h10, 32'h1234_AAEF);
        ld(3'b001, 32'h12, 32'h0000_1234);
        ld(3'b101, 32'h10, 32'h0000_AAEF);
`ifdef LSU_MISALIGN_TRAP_EN
        bad_req(1'b0, 3'b010, 32'h13);
`else
        ld(3'b010, 32'h13, 32'h1234_AAEF);
`endif

        // Reset during RD_WAIT of SB 0x11: no write, no done.
        while (!ready) @(negedge clk);
        we = 1'b1; funct3 = 3'b000; addr = 32'h11; wdata = 32'h55; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wren", 32'(mem_wren), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        held = '0;
        check("abort_no_write", 32'(wren_cnt), 32'd0);
        wren_cnt = 0;
        ld(3'b010, 32'h10, 32'h1234_AAEF);

        // req while busy is ignored.
        start(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 1'b1, 32'h1234_AAEF, RD_LAT + 2, 0);
        @(negedge clk);
        we = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);
        ld(3'b010, 32'h10, 32'h1234_AAEF);

        // Illegal types.
        bad_req(1'b0, 3'b011, 32'h10);
        bad_req(1'b1, 3'b100, 32'h10);
        bad_req(1'b1, 3'b110, 32'h10);
        ld(3'b010, 32'h10, 32'h1234_AAEF);

        // Remaining lanes and sign cases.
        st(3'b000, 32'h13, 32'hFFFF_FF7F);
        ld(3'b010, 32'h10, 32'h7F34_AAEF);
        ld(3'b000, 32'h13, 32'h0000_007F);
        st(3'b001, 32'h10, 32'h0000_8001);
        ld(3'b001, 32'h10, 32'hFFFF_8001);
        ld(3'b101, 32'h12, 32'h0000_7F34);
        ld(3'b000, 32'h12, 32'h0000_0034);
        // Wrap: address bits above MEM_AW+1 ignored.
        ld(3'b010, 32'h0000_0410, 32'h7F34_8001);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
